// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone initiator types and constants
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;
  localparam int unsigned WB_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  // Sticks at all-ones so a long wait can never wrap back under the limit
  function automatic logic [WB_CNT_W-1:0] sat_inc(input logic [WB_CNT_W-1:0] v);
    return (v == {WB_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// rtl/wb_initiator_if.sv - pipelined Wishbone bus bundle with initiator/responder views
interface if_wb
  import wb_pkg::*;
#(
  parameter int unsigned AW = 32
) ();

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_SEL_W-1:0]  sel;
  logic [AW-1:0]        adr;
  logic [WB_DATA_W-1:0] dat_m;
  logic [WB_DATA_W-1:0] dat_s;
  logic                 ack;
  logic                 stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, stall
  );

endinterface

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding pipelined Wishbone initiator with ack timeout
module wb_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  if_wb.master                 bus,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_adr,
  input  logic [WB_SEL_W-1:0]  req_sel,
  input  logic [WB_DATA_W-1:0] req_dat,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WB_DATA_W-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [WB_CNT_W-1:0] CNT_LIMIT = WB_CNT_W'(TIMEOUT);

  wb_state_e            state_q, state_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        adr_q, adr_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [WB_DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WB_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WB_CNT_W-1:0]  cnt_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt_inc = sat_inc(cnt_q);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_REQ;
          we_d    = req_we;
          adr_d   = req_adr;
          sel_d   = req_sel;
          dat_d   = req_dat;
        end
      end
      ST_REQ: begin
        // A stalled strobe waits indefinitely; the timeout only covers the ack phase
        if (!bus.stall) begin
          cnt_d = '0;
          if (bus.ack) begin
            state_d   = ST_RESP;
            rsp_dat_d = we_q ? '0 : bus.dat_s;
            rsp_err_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // Ack wins over a timeout landing on the same cycle
        if (bus.ack) begin
          state_d   = ST_RESP;
          rsp_dat_d = we_q ? '0 : bus.dat_s;
          rsp_err_d = 1'b0;
        end else if (cnt_inc >= CNT_LIMIT) begin
          state_d   = ST_RESP;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    bus.cyc   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    bus.stb   = (state_q == ST_REQ);
    bus.we    = we_q;
    bus.sel   = sel_q;
    bus.adr   = adr_q;
    bus.dat_m = dat_q;
    rsp_dat   = rsp_dat_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - directed scoreboard bench for wb_initiator against a segment-controller responder
module tb_wb_initiator;
  import wb_pkg::*;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  if_wb #(.AW(32)) bus ();

  wb_initiator #(.TIMEOUT(TMO), .AW(32)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_sel   (req_sel),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Responder: register at 0x0, switches at 0x4, ack one cycle after acceptance
  logic [31:0] seg_reg = '0;
  logic [9:0]  switches = 10'h2A5;
  int          stall_req = 0;
  int          stall_seen = 0;
  logic        no_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        ack_q = 1'b0;
  logic [31:0] rd_q = 32'h0BAD_0BAD;

  assign bus.stall = bus.stb && (stall_seen < stall_req);
  assign bus.ack   = ack_q | stray_ack;
  assign bus.dat_s = rd_q;

  always @(posedge clk) begin
    ack_q <= 1'b0;
    if (!bus.stb) stall_seen <= 0;
    else if (bus.stall) stall_seen <= stall_seen + 1;
    if (bus.cyc && bus.stb && !bus.stall && !no_ack) begin
      ack_q <= 1'b1;
      if (bus.we) begin
        for (int b = 0; b < 4; b++)
          if (bus.sel[b]) seg_reg[8*b +: 8] <= bus.dat_m[8*b +: 8];
        rd_q <= 32'hBAD0_0000;
      end else begin
        rd_q <= (bus.adr == 32'h0) ? seg_reg :
                (bus.adr == 32'h4) ? {22'b0, switches} : 32'hDEAD_BEEF;
      end
    end
  end

  int stb_total = 0;
  int wait_total = 0;
  int unstable_total = 0;
  int hs_total = 0;
  logic        prev_stb = 1'b0;
  logic        prev_we = 1'b0;
  logic [3:0]  prev_sel = '0;
  logic [31:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;

  always @(negedge clk) begin
    if (bus.cyc && bus.stb) stb_total++;
    if (bus.cyc && !bus.stb) wait_total++;
    if (bus.stb && prev_stb &&
        (bus.adr !== prev_adr || bus.dat_m !== prev_dat || bus.sel !== prev_sel || bus.we !== prev_we))
      unstable_total++;
    if (rsp_valid && rsp_ready) hs_total++;
    prev_stb = bus.stb;
    prev_adr = bus.adr;
    prev_dat = bus.dat_m;
    prev_sel = bus.sel;
    prev_we  = bus.we;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the request was taken
  task automatic issue(input string tag, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       input logic [31:0] want_dat, input logic want_err);
    int n = 0;
    exp_t e;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_sel   = sel;
    req_dat   = dat;
    e.dat = want_dat;
    e.err = want_err;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold, output int lat);
    int n = 0;
    exp_t e;
    e.dat = 'x;
    e.err = 1'bx;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ".sb_pending"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, ".rsp_dat"}, rsp_dat, e.dat);
    chk({tag, ".rsp_err"}, rsp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      stray_ack = (i == 2);
      @(negedge clk);
      chk({tag, ".hold_valid"}, rsp_valid, 1'b1);
      chk({tag, ".hold_dat"}, rsp_dat, e.dat);
      chk({tag, ".hold_err"}, rsp_err, e.err);
      chk({tag, ".hold_req_ready"}, req_ready, 1'b0);
      chk({tag, ".hold_stb"}, bus.stb, 1'b0);
    end
    stray_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int s0, w0, u0, h0, lat, n;

    repeat (2) @(negedge clk);
    chk("rst.cyc", bus.cyc, 1'b0);
    chk("rst.stb", bus.stb, 1'b0);
    chk("rst.adr", bus.adr, 32'h0);
    chk("rst.dat_m", bus.dat_m, 32'h0);
    chk("rst.sel", bus.sel, 4'h0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle.req_ready", req_ready, 1'b1);

    // Write then read back through register 0x0
    s0 = stb_total; w0 = wait_total;
    issue("wr0", 1'b1, 32'h0, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
    chk("wr0.busy", busy, 1'b1);
    collect("wr0", 0, lat);
    chk("wr0.latency", lat, 2);
    chk("wr0.stb_cycles", stb_total - s0, 1);
    chk("wr0.wait_cycles", wait_total - w0, 1);
    issue("rd0", 1'b0, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    collect("rd0", 0, lat);

    issue("rd4", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_02A5, 1'b0);
    collect("rd4", 0, lat);

    // Stalled partial write: low half only
    stall_req = 3;
    s0 = stb_total; u0 = unstable_total; h0 = hs_total;
    issue("stall", 1'b1, 32'h0, 4'b0011, 32'hCAFE_F00D, 32'h0, 1'b0);
    collect("stall", 0, lat);
    chk("stall.stb_cycles", stb_total - s0, 4);
    chk("stall.unstable", unstable_total - u0, 0);
    chk("stall.completions", hs_total - h0, 1);
    stall_req = 0;
    issue("rd_sel", 1'b0, 32'h0, 4'hF, 32'h0, 32'h1234_F00D, 1'b0);
    collect("rd_sel", 0, lat);

    // Responder never acks
    no_ack = 1'b1;
    w0 = wait_total;
    issue("tmo", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0, 1'b1);
    collect("tmo", 0, lat);
    chk("tmo.wait_cycles", wait_total - w0, TMO);
    no_ack = 1'b0;

    // Response held off, with a stray ack landing in RESP
    switches = 10'h15A;
    issue("hold", 1'b0, 32'h4, 4'hF, 32'h0, 32'h0000_015A, 1'b0);
    collect("hold", 5, lat);

    // Stray ack in IDLE
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    chk("stray.busy", busy, 1'b0);
    chk("stray.rsp_valid", rsp_valid, 1'b0);
    chk("stray.req_ready", req_ready, 1'b1);

    // Reset while waiting for an ack
    no_ack = 1'b1;
    issue("rstw", 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (!(bus.cyc && !bus.stb) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstw.in_wait", bus.cyc && !bus.stb, 1'b1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rstw.cyc", bus.cyc, 1'b0);
    chk("rstw.busy", busy, 1'b0);
    chk("rstw.rsp_valid", rsp_valid, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    no_ack = 1'b0;
    h0 = hs_total;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw.no_rsp", rsp_valid, 1'b0);
    end
    issue("wr_a5", 1'b1, 32'h0, 4'hF, 32'h0000_00A5, 32'h0, 1'b0);
    collect("wr_a5", 0, lat);
    issue("rd_a5", 1'b0, 32'h0, 4'hF, 32'h0, 32'h0000_00A5, 1'b0);
    collect("rd_a5", 0, lat);
    chk("rstw.completions", hs_total - h0, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
